muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-bit MULT/MULTU/DIV/DIVU unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
// Signs are applied when the last iteration completes.
// Build option: define MULDIV_FAST_MUL_EN so that MULT/MULTU use a single-cycle
// 32x32 multiplier and finish after one BUSY cycle. Division always takes 32 iterations.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ACCW      = 2 * XLEN;
    localparam int unsigned CNTW      = 6;
    localparam int unsigned LAST_ITER = 31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   a_q, a_d;          // raw dividend, returned in hi on divide-by-zero
    logic [XLEN-1:0]   bmag_q, bmag_d;    // |b|
    logic [ACCW-1:0]   acc_q, acc_d;      // {partial product | remainder, multiplier | quotient}
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              cancel_q;

    logic              sgn_c;
    logic [XLEN-1:0]   amag_c, bmag_c;
    logic [XLEN:0]     mul_sum_c;
    logic [XLEN:0]     div_try_c;
    logic              div_ge_c;
    logic [XLEN-1:0]   div_rem_c;
    logic [ACCW-1:0]   acc_step_c;
    logic [ACCW-1:0]   prod_c;
    logic              fast_mul_c;
    logic              last_c;
    logic [XLEN-1:0]   res_hi_c, res_lo_c;

    // Operand magnitudes; |-2^31| = 2^31 still fits an unsigned 32-bit value.
    always_comb begin
        sgn_c  = ~op[0];
        amag_c = (sgn_c && a[XLEN-1]) ? XLEN'(~a + XLEN'(1)) : a;
        bmag_c = (sgn_c && b[XLEN-1]) ? XLEN'(~b + XLEN'(1)) : b;
    end

    // One radix-2 iteration of multiply or divide, plus final sign fix-up.
    always_comb begin
        mul_sum_c = {1'b0, acc_q[ACCW-1:XLEN]} + (acc_q[0] ? {1'b0, bmag_q} : '0);
        div_try_c = {acc_q[ACCW-1:XLEN], acc_q[XLEN-1]};
        div_ge_c  = div_try_c >= {1'b0, bmag_q};
        div_rem_c = div_ge_c ? XLEN'(div_try_c - {1'b0, bmag_q}) : XLEN'(div_try_c);

`ifdef MULDIV_FAST_MUL_EN
        fast_mul_c = ~is_div_q;
`else
        fast_mul_c = 1'b0;
`endif

        if (is_div_q) begin
            acc_step_c = {div_rem_c, acc_q[XLEN-2:0], div_ge_c};
        end else begin
            acc_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
`ifdef MULDIV_FAST_MUL_EN
            acc_step_c = ACCW'(ACCW'(acc_q[XLEN-1:0]) * ACCW'(bmag_q));
`endif
        end

        last_c = fast_mul_c || (cnt_q == CNTW'(LAST_ITER));

        prod_c = neg_lo_q ? ACCW'(~acc_step_c + ACCW'(1)) : acc_step_c;
        if (!is_div_q) begin
            res_hi_c = prod_c[ACCW-1:XLEN];
            res_lo_c = prod_c[XLEN-1:0];
        end else if (bmag_q == '0) begin
            res_hi_c = a_q;
            res_lo_c = '1;
        end else begin
            res_lo_c = neg_lo_q ? XLEN'(~acc_step_c[XLEN-1:0] + XLEN'(1)) : acc_step_c[XLEN-1:0];
            res_hi_c = neg_hi_q ? XLEN'(~acc_step_c[ACCW-1:XLEN] + XLEN'(1)) : acc_step_c[ACCW-1:XLEN];
        end
    end

    // Next-state, datapath load and stall request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        a_d       = a_q;
        bmag_d    = bmag_q;
        acc_d     = acc_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        stall_req = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // The cycle after a flush never accepts, so the stall stays low there.
                if (start && !cancel && !cancel_q) begin
                    stall_req = 1'b1;
                    state_d   = S_BUSY;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    a_d       = a;
                    bmag_d    = bmag_c;
                    acc_d     = {{XLEN{1'b0}}, amag_c};
                    neg_lo_d  = sgn_c & (a[XLEN-1] ^ b[XLEN-1]);
                    neg_hi_d  = sgn_c & a[XLEN-1];
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_step_c;
                    cnt_d = cnt_q + CNTW'(1);
                    if (last_c) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hi_d    = res_hi_c;
                        lo_d    = res_lo_c;
                    end
                end
            end
            S_DONE: begin
                stall_req = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            a_q      <= '0;
            bmag_q   <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            bmag_q   <= bmag_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            cancel_q <= cancel;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
